// File: rtl/lift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lift_pkg                                                        |
// | Purpose  : Shared types and helpers for the SCAN lift controller: FSM      |
// |            state encoding, travel direction, and the above/below request   |
// |            mask helper used for "requests ahead" decisions.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package lift_pkg;

  // Widest floor bitmap the controller supports; narrower maps are zero-extended.
  localparam int unsigned c_max_floors = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  typedef struct packed {
    logic [c_max_floors-1:0] above;
    logic [c_max_floors-1:0] below;
  } ahead_t;

  // Splits a pending bitmap into the requests strictly above and strictly
  // below the given floor. The floor's own bit appears in neither mask.
  function automatic ahead_t ahead_masks(input logic [c_max_floors-1:0] pend,
                                         input int unsigned             floor_idx);
    ahead_t m;
    m = '0;
    for (int unsigned i = 0; i < c_max_floors; i++) begin
      m.above[i] = pend[i] && (i > floor_idx);
      m.below[i] = pend[i] && (i < floor_idx);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lift_scan_controller_key_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_edge_sync                                                   |
// | Purpose  : Two-flop synchroniser for the active-low request pushbutton     |
// |            followed by a falling-edge detector. Emits a one-cycle pulse    |
// |            per press, however long the button is held.                     |
// | Ports    : clk      - system clock                                         |
// |            rst      - asynchronous active-high reset                       |
// |            i_key_n  - raw active-low button, asynchronous to clk           |
// |            o_fall   - one-cycle press event                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module key_edge_sync
  import lift_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // All flops reset to 1 (button released) so reset release never fakes a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_fall = r_prev & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/lift_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lift_scan_controller                                            |
// | Purpose  : Multi-request lift controller. Latches floor requests into a    |
// |            pending bitmap and serves them in SCAN order with a per-floor   |
// |            travel time and a timed door dwell.                             |
// | Ports    : CLOCK_50  - system clock                                        |
// |            RESET     - asynchronous active-high reset                      |
// |            SW        - request selection, bit i = floor i                  |
// |            KEY0      - active-low request pushbutton (async)               |
// |            floor_cur - current floor, binary                               |
// |            pending   - outstanding request bitmap                          |
// |            dir_up    - cabin travelling up                                 |
// |            dir_down  - cabin travelling down                               |
// |            LED_G     - door open                                           |
// |            LED_R     - door closed (always ~LED_G)                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lift_scan_controller
  import lift_pkg::*;
#(
  parameter  int unsigned N_FLOORS        = 9,
  parameter  int unsigned TICKS_PER_FLOOR = 50_000_000,
  parameter  int unsigned DOOR_TICKS      = 100_000_000,
  localparam int unsigned FW              = (N_FLOORS > 2) ? $clog2(N_FLOORS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [N_FLOORS-1:0] SW,
  input  logic                KEY0,
  output logic [FW-1:0]       floor_cur,
  output logic [N_FLOORS-1:0] pending,
  output logic                dir_up,
  output logic                dir_down,
  output logic                LED_G,
  output logic                LED_R
);

  localparam int unsigned c_tmax = (TICKS_PER_FLOOR > DOOR_TICKS) ? TICKS_PER_FLOOR : DOOR_TICKS;
  localparam int unsigned c_tw   = $clog2(c_tmax + 1);
  localparam logic [c_tw-1:0] c_tick_load = c_tw'(TICKS_PER_FLOOR - 1);
  localparam logic [c_tw-1:0] c_door_load = c_tw'(DOOR_TICKS - 1);

  logic                w_key_evt;
  state_t              r_state;
  state_t              w_state_nx;
  dir_t                r_last_dir;
  dir_t                w_last_dir_nx;
  logic [FW-1:0]       r_floor;
  logic [FW-1:0]       w_floor_nx;
  logic [FW-1:0]       w_step_floor;
  logic [c_tw-1:0]     r_timer;
  logic [c_tw-1:0]     w_timer_nx;
  logic [N_FLOORS-1:0] r_pending;
  logic [N_FLOORS-1:0] w_pending_nx;
  logic [N_FLOORS-1:0] w_req;
  logic [N_FLOORS-1:0] w_req_keep;
  logic [N_FLOORS-1:0] w_clear;
  logic [N_FLOORS-1:0] w_cur_onehot;
  logic [N_FLOORS-1:0] w_step_onehot;
  ahead_t              w_cur_masks;
  ahead_t              w_step_masks;
  logic                w_cur_hit;
  logic                w_any_above;
  logic                w_any_below;
  logic                w_step_above;
  logic                w_step_below;

  key_edge_sync u_key_edge_sync (
    .clk     (CLOCK_50),
    .rst     (RESET),
    .i_key_n (KEY0),
    .o_fall  (w_key_evt)
  );

  assign w_req     = w_key_evt ? SW : '0;
  assign w_cur_hit = w_key_evt & SW[r_floor];

  // Floor the cabin arrives at when the travel timer expires. Only meaningful
  // in the MOVE states, which are never entered at the end stops.
  assign w_step_floor = (r_state == MOVE_DOWN) ? (r_floor - FW'(1)) : (r_floor + FW'(1));

  assign w_cur_onehot  = N_FLOORS'(1) << r_floor;
  assign w_step_onehot = N_FLOORS'(1) << w_step_floor;

  assign w_cur_masks  = ahead_masks(c_max_floors'(r_pending), 32'(r_floor));
  assign w_step_masks = ahead_masks(c_max_floors'(r_pending), 32'(w_step_floor));
  assign w_any_above  = |w_cur_masks.above;
  assign w_any_below  = |w_cur_masks.below;
  assign w_step_above = |w_step_masks.above;
  assign w_step_below = |w_step_masks.below;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_last_dir <= UP;
      r_floor    <= '0;
      r_timer    <= '0;
      r_pending  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_last_dir <= w_last_dir_nx;
      r_floor    <= w_floor_nx;
      r_timer    <= w_timer_nx;
      r_pending  <= w_pending_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_last_dir_nx = r_last_dir;
    w_floor_nx    = r_floor;
    w_timer_nx    = r_timer;
    w_req_keep    = w_req;
    w_clear       = '0;

    unique case (r_state)
      IDLE: begin
        // A press for the floor we are parked at opens the door instead of
        // becoming a pending request.
        w_req_keep = w_req & ~w_cur_onehot;
        if (r_pending[r_floor] || w_cur_hit) begin
          w_clear    = w_cur_onehot;
          w_state_nx = DOOR_OPEN;
          w_timer_nx = c_door_load;
        end else if (w_any_above && ((r_last_dir == UP) || !w_any_below)) begin
          w_state_nx    = MOVE_UP;
          w_last_dir_nx = UP;
          w_timer_nx    = c_tick_load;
        end else if (w_any_below) begin
          w_state_nx    = MOVE_DOWN;
          w_last_dir_nx = DOWN;
          w_timer_nx    = c_tick_load;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (r_timer != '0) begin
          w_timer_nx = r_timer - c_tw'(1);
        end else begin
          // Arrival: step the floor and decide stop / continue / idle on the
          // same edge so adjacent floors are exactly TICKS_PER_FLOOR apart.
          w_floor_nx = w_step_floor;
          if (r_pending[w_step_floor]) begin
            w_clear    = w_step_onehot;
            w_state_nx = DOOR_OPEN;
            w_timer_nx = c_door_load;
          end else if ((r_state == MOVE_UP) ? w_step_above : w_step_below) begin
            w_timer_nx = c_tick_load;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end

      DOOR_OPEN: begin
        // Re-pressing the open floor extends the dwell rather than queueing.
        w_req_keep = w_req & ~w_cur_onehot;
        if (w_cur_hit) begin
          w_timer_nx = c_door_load;
        end else if (r_timer == '0) begin
          w_state_nx = IDLE;
        end else begin
          w_timer_nx = r_timer - c_tw'(1);
        end
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Clear beats a same-cycle request for the floor being served.
  assign w_pending_nx = (r_pending | w_req_keep) & ~w_clear;

  assign floor_cur = r_floor;
  assign pending   = r_pending;
  assign dir_up    = (r_state == MOVE_UP);
  assign dir_down  = (r_state == MOVE_DOWN);
  assign LED_G     = (r_state == DOOR_OPEN);
  assign LED_R     = ~LED_G;

endmodule
`default_nettype wire

// File: tb/tb_lift_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_lift_scan_controller                                         |
// | Purpose  : Self-checking bench for lift_scan_controller (8 floors, 4 ticks |
// |            per floor, 6 door ticks): vector table, SCAN/hold/dwell/reset   |
// |            sequences, and randomized traffic against a reference model.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_lift_scan_controller;

  localparam int TPF = 4;
  localparam int DT  = 6;
  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DN   = 2;
  localparam int M_DOOR = 3;

  logic       CLOCK_50;
  logic       RESET;
  logic [7:0] SW;
  logic       KEY0;
  logic [2:0] floor_cur;
  logic [7:0] pending;
  logic       dir_up;
  logic       dir_down;
  logic       LED_G;
  logic       LED_R;

  lift_scan_controller #(
    .N_FLOORS        (8),
    .TICKS_PER_FLOOR (TPF),
    .DOOR_TICKS      (DT)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .SW        (SW),
    .KEY0      (KEY0),
    .floor_cur (floor_cur),
    .pending   (pending),
    .dir_up    (dir_up),
    .dir_down  (dir_down),
    .LED_G     (LED_G),
    .LED_R     (LED_R)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: mode, floor, request set, preferred direction and the
  // number of cycles left in the current leg or dwell.
  int         m_mode;
  int         m_floor;
  logic [7:0] m_pend;
  bit         m_up;
  int         m_left;
  bit         m_k1, m_k2, m_k3;

  // Observation bookkeeping taken from the DUT outputs.
  int  d_q[$];
  bit  prev_g;
  int  max_fl;
  bit  saw_dn;

  function automatic bit any_in(logic [7:0] p, int lo, int hi);
    for (int i = lo; i <= hi; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_floor = 0; m_pend = 8'h00; m_up = 1'b1; m_left = 0;
    m_k1 = 1'b1; m_k2 = 1'b1; m_k3 = 1'b1;
  endtask

  // One clock edge of the lift's rules. A press is seen two edges after the
  // button is first sampled low, i.e. when the sample three edges back was
  // high and the one two edges back was low.
  task automatic model_step();
    bit         evt, go_up, go_dn, ahead;
    logic [7:0] req, pnew;
    if (RESET) begin model_reset(); return; end
    evt  = m_k3 && !m_k2;
    m_k3 = m_k2; m_k2 = m_k1; m_k1 = KEY0;
    req  = evt ? SW : 8'h00;
    pnew = m_pend | req;
    case (m_mode)
      M_IDLE: begin
        pnew[m_floor] = 1'b0;
        if (m_pend[m_floor] || req[m_floor]) begin
          m_mode = M_DOOR; m_left = DT;
        end else begin
          go_up = any_in(m_pend, m_floor + 1, 7);
          go_dn = any_in(m_pend, 0, m_floor - 1);
          if (go_up && (m_up || !go_dn)) begin m_mode = M_UP; m_up = 1'b1; m_left = TPF; end
          else if (go_dn)                begin m_mode = M_DN; m_up = 1'b0; m_left = TPF; end
        end
      end
      M_UP, M_DN: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += (m_mode == M_UP) ? 1 : -1;
          ahead = (m_mode == M_UP) ? any_in(m_pend, m_floor + 1, 7) : any_in(m_pend, 0, m_floor - 1);
          if (m_pend[m_floor]) begin pnew[m_floor] = 1'b0; m_mode = M_DOOR; m_left = DT; end
          else if (ahead)      m_left = TPF;
          else                 m_mode = M_IDLE;
        end
      end
      default: begin
        pnew[m_floor] = 1'b0;
        if (req[m_floor]) m_left = DT;
        else begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
    m_pend = pnew;
  endtask

  task automatic chk(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Advance one clock, update the model and compare every output.
  task automatic cyc();
    bit eg;
    @(posedge CLOCK_50);
    model_step();
    #1;
    eg = (m_mode == M_DOOR);
    n_checks++;
    if (floor_cur !== 3'(m_floor) || pending !== m_pend || dir_up !== (m_mode == M_UP) ||
        dir_down !== (m_mode == M_DN) || LED_G !== eg || LED_R !== !eg) begin
      n_errs++;
      $display("FAIL model t=%0t got fl=%0d pend=%h up=%b dn=%b g=%b r=%b exp fl=%0d pend=%h up=%b dn=%b g=%b",
               $time, floor_cur, pending, dir_up, dir_down, LED_G, LED_R,
               m_floor, m_pend, m_mode == M_UP, m_mode == M_DN, eg);
    end
    if (LED_G && !prev_g) d_q.push_back(int'(floor_cur));
    prev_g = LED_G;
    if (int'(floor_cur) > max_fl) max_fl = int'(floor_cur);
    if (dir_down) saw_dn = 1'b1;
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must
  // return to reset values before the next edge.
  task automatic do_reset(string tag);
    RESET = 1'b1;
    #1;
    chk({tag, "_rst_floor"}, int'(floor_cur), 0);
    chk({tag, "_rst_pend"},  int'(pending), 0);
    chk({tag, "_rst_ledg"},  int'(LED_G), 0);
    chk({tag, "_rst_ledr"},  int'(LED_R), 1);
    chk({tag, "_rst_dir"},   int'({dir_up, dir_down}), 0);
    model_reset();
    cyc();
    RESET = 1'b0;
  endtask

  task automatic press(logic [7:0] sw);
    SW = sw; KEY0 = 1'b0;
    cyc();
    KEY0 = 1'b1;
  endtask

  typedef struct {
    logic [7:0] sw;
    logic       key;
    int         n;
    int         fl;
    logic [7:0] pend;
    logic       up;
    logic       dn;
    logic       g;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int k;
    int cnt;
    RESET = 1'b1; SW = 8'h00; KEY0 = 1'b1;
    prev_g = 1'b0; max_fl = 0; saw_dn = 1'b0;
    model_reset();

    // {SW, KEY0, cycles, floor, pending, dir_up, dir_down, LED_G}
    vecs[0]  = '{8'h08, 1'b0, 2,  0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h08, 1'b0, 1,  0, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h08, 1'b1, 1,  0, 8'h08, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'h08, 1'b1, 3,  0, 8'h08, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h08, 1'b1, 1,  1, 8'h08, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h08, 1'b1, 8,  3, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h08, 1'b1, 5,  3, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h08, 1'b1, 1,  3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h08, 1'b0, 2,  3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h08, 1'b0, 1,  3, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h08, 1'b1, 5,  3, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{8'h08, 1'b1, 1,  3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h01, 1'b0, 3,  3, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'h01, 1'b1, 1,  3, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{8'h01, 1'b1, 12, 0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{8'h01, 1'b1, 6,  0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{8'h01, 1'b0, 2,  0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{8'h01, 1'b0, 1,  0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{8'h01, 1'b1, 6,  0, 8'h00, 1'b0, 1'b0, 1'b0};

    @(posedge CLOCK_50);
    #1;
    do_reset("init");

    for (int i = 0; i < 19; i++) begin
      SW = vecs[i].sw; KEY0 = vecs[i].key;
      repeat (vecs[i].n) cyc();
      n_checks++;
      if (floor_cur !== 3'(vecs[i].fl) || pending !== vecs[i].pend || dir_up !== vecs[i].up ||
          dir_down !== vecs[i].dn || LED_G !== vecs[i].g || LED_R !== !vecs[i].g) begin
        n_errs++;
        $display("FAIL vec%0d got fl=%0d pend=%h up=%b dn=%b g=%b r=%b exp fl=%0d pend=%h up=%b dn=%b g=%b",
                 i, floor_cur, pending, dir_up, dir_down, LED_G, LED_R,
                 vecs[i].fl, vecs[i].pend, vecs[i].up, vecs[i].dn, vecs[i].g);
      end
    end

    // SCAN order: heading up to 6, add 2 and 5 while passing floor 4.
    d_q.delete(); saw_dn = 1'b0;
    press(8'h40);
    k = 0;
    while (!(floor_cur == 3'd4 && dir_up) && k < 100) begin cyc(); k++; end
    chk("scan_reach4_in_time", int'(k < 100), 1);
    press(8'h24);
    k = 0;
    while (!(pending == 8'h00 && !LED_G && !dir_up && !dir_down) && k < 200) begin cyc(); k++; end
    chk("scan_done_in_time", int'(k < 200), 1);
    chk("scan_stops", d_q.size(), 3);
    if (d_q.size() == 3) begin
      chk("scan_stop0", d_q[0], 5);
      chk("scan_stop1", d_q[1], 6);
      chk("scan_stop2", d_q[2], 2);
    end
    chk("scan_reversed", int'(saw_dn), 1);

    // Button held low for 100 cycles: one request, one stop at the top.
    d_q.delete(); max_fl = 0;
    SW = 8'h80; KEY0 = 1'b0;
    repeat (100) cyc();
    KEY0 = 1'b1;
    repeat (5) cyc();
    chk("hold_stops", d_q.size(), 1);
    if (d_q.size() == 1) chk("hold_stop_floor", d_q[0], 7);
    chk("hold_max_floor", max_fl, 7);
    chk("hold_final_floor", int'(floor_cur), 7);
    chk("hold_pending", int'(pending), 0);

    // Re-press the open floor: dwell restarts, no request latched.
    press(8'h04);
    k = 0;
    while (!LED_G && k < 100) begin cyc(); k++; end
    chk("dwell_open_in_time", int'(k < 100), 1);
    chk("dwell_floor", int'(floor_cur), 2);
    repeat (2) cyc();
    SW = 8'h04; KEY0 = 1'b0;
    cnt = 0; k = 0;
    do begin
      cyc();
      KEY0 = 1'b1;
      if (LED_G) cnt++;
      if (pending[2]) chk("dwell_no_latch", 1, 0);
      k++;
    end while (LED_G && k < 30);
    chk("dwell_cycles_after_repress", cnt, 8);
    chk("dwell_pending", int'(pending), 0);

    // Reset while travelling.
    press(8'h20);
    repeat (8) cyc();
    chk("midrun_moving", int'(dir_up), 1);
    do_reset("midrun");
    SW = 8'h20;
    repeat (20) cyc();
    chk("midrun_floor_after", int'(floor_cur), 0);
    chk("midrun_dir_after", int'({dir_up, dir_down}), 0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) KEY0 = ~KEY0;
      if ($urandom_range(0, 5) == 0) SW = 8'($urandom & $urandom);
      if ($urandom_range(0, 699) == 0) do_reset("rand");
      else cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
